// File: rtl/regfile_dump_reader.sv
// Register array with a streaming dump port.
// A dump walks every entry in address order over a valid/ready handshake.
module regfile_dump_reader #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              dump_done
);

    typedef enum logic [1:0] {IDLE, PRESENT, DONE} state_t;

    localparam logic [ADDR_W:0]   NUM_EXT   = NUM_REGS[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] cap;
    logic              wr_ok;
    logic              xfer;
    logic              last;
    logic              advance;

    assign wr_ok = we && ({1'b0, waddr} < NUM_EXT)
                   && !(ZERO_REG0 && (waddr == '0));
    assign xfer  = (state_q == PRESENT) && out_ready;
    assign last  = (addr_q == LAST_ADDR);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (dump_start) state_d = PRESENT;
            PRESENT: if (xfer && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == PRESENT);
        dump_busy = (state_q != IDLE);
        dump_done = (state_q == DONE);
    end

    assign out_addr = addr_q;
    assign out_data = data_q;

    // Capture reads the post-write array so a same-edge write is bypassed
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_ok && (waddr == ADDR_W'(i))) mem_d[i] = wdata;
        end
        nxt_addr = (state_q == IDLE) ? '0 : addr_q + 1'b1;
        cap = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (nxt_addr == ADDR_W'(i)) cap = mem_d[i];
        end
        advance = ((state_q == IDLE) && dump_start) || (xfer && !last);
        addr_d = addr_q;
        data_d = data_q;
        if (advance) begin
            addr_d = nxt_addr;
            data_d = cap;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            data_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader.
// Stimulus pushes expected entries; a negedge monitor pops and checks them.
module tb_regfile_dump_reader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        dump_start = 1'b0;
    logic        dump_busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        dump_done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    logic [4:0]  q_addr [$];
    logic [31:0] q_data [$];
    logic [31:0] model [32];
    logic [31:0] expv [32];

    logic        held = 1'b0;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    logic        pend = 1'b0;

    regfile_dump_reader dut (
        .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr),
        .wdata(wdata), .dump_start(dump_start), .dump_busy(dump_busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .dump_done(dump_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops, hold stability, done pulse timing
    always @(negedge clock) begin
        if (!reset_n) begin
            held = 1'b0;
            pend = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_addr", {27'b0, out_addr}, {27'b0, h_addr});
                chk("hold_data", out_data, h_data);
            end
            held = out_valid && !out_ready;
            h_addr = out_addr;
            h_data = out_data;
            if (pend || dump_done)
                chk("done_pulse", {31'b0, dump_done}, {31'b0, pend});
            if (dump_done) done_cnt++;
            pend = out_valid && out_ready && (out_addr == 5'd31);
            if (out_valid && out_ready) begin
                if (q_addr.size() == 0) begin
                    chk("unexpected_xfer", {27'b0, out_addr}, 32'hFFFFFFFF);
                end else begin
                    chk("xfer_addr", {27'b0, out_addr},
                        {27'b0, q_addr.pop_front()});
                    chk("xfer_data", out_data, q_data.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic push_exp();
        for (int i = 0; i < 32; i++) begin
            q_addr.push_back(5'(i));
            q_data.push_back(expv[i]);
        end
    endtask

    task automatic load_exp();
        for (int i = 0; i < 32; i++) expv[i] = model[i];
    endtask

    // pat 0: always ready; pat 1: ready 1,0,0 repeating
    task automatic run_to_end(input int pat, input int start_at, input int dc0);
        int cyc;
        cyc = 0;
        while (dump_busy && cyc < 400) begin
            out_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
            dump_start = (cyc == start_at);
            tick();
            cyc++;
        end
        dump_start = 1'b0;
        if (cyc >= 400) chk("dump_timeout", 32'(cyc), 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("idle_after_dump", {31'b0, dump_busy}, 32'd0);
        chk("done_count", 32'(done_cnt - dc0), 32'd1);
        chk("queue_empty", 32'(q_addr.size()), 32'd0);
    endtask

    task automatic do_dump(input int pat, input int start_at);
        int dc0;
        dc0 = done_cnt;
        push_exp();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("start_latency", {31'b0, out_valid}, 32'd1);
        chk("first_addr", {27'b0, out_addr}, 32'd0);
        run_to_end(pat, start_at, dc0);
    endtask

    initial begin
        int cyc;
        int dc0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        #3;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, dump_busy}, 32'd0);
        chk("rst_done", {31'b0, dump_done}, 32'd0);
        chk("rst_addr", {27'b0, out_addr}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: all-zero dump, full throughput
        load_exp();
        do_dump(0, -1);

        // 2: writes then dump; r0 stays 0
        wr(5'd5, 32'hDEADBEEF);
        wr(5'd31, 32'h12345678);
        wr(5'd0, 32'hFFFFFFFF);
        model[5] = 32'hDEADBEEF;
        model[31] = 32'h12345678;
        load_exp();
        do_dump(0, -1);

        // 3: backpressure 1,0,0 pattern
        load_exp();
        do_dump(1, -1);

        // 4: stall at r3 with writes, same-edge write to r4 on advance
        load_exp();
        expv[10] = 32'hBB;
        expv[4] = 32'h44;
        push_exp();
        dc0 = done_cnt;
        out_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        cyc = 0;
        while (!(out_valid && out_addr == 5'd3) && cyc < 50) begin
            tick();
            cyc++;
        end
        if (cyc >= 50) chk("stall3_timeout", 32'(cyc), 32'd0);
        out_ready = 1'b0;
        wr(5'd3, 32'hAA);
        wr(5'd10, 32'hBB);
        wr(5'd1, 32'hCC);
        out_ready = 1'b1;
        wr(5'd4, 32'h44);
        run_to_end(0, -1, dc0);
        model[3] = 32'hAA;
        model[10] = 32'hBB;
        model[1] = 32'hCC;
        model[4] = 32'h44;

        // 5: dump_start mid-dump ignored
        load_exp();
        do_dump(0, 6);

        // 6: async reset at r17 aborts the dump
        load_exp();
        push_exp();
        dc0 = done_cnt;
        out_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        cyc = 0;
        while (!(out_valid && out_addr == 5'd17) && cyc < 50) begin
            tick();
            cyc++;
        end
        if (cyc >= 50) chk("r17_timeout", 32'(cyc), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_busy", {31'b0, dump_busy}, 32'd0);
        chk("abort_addr", {27'b0, out_addr}, 32'd0);
        chk("abort_data", out_data, 32'd0);
        q_addr.delete();
        q_data.delete();
        tick();
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) model[i] = '0;
        load_exp();
        do_dump(0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
